mem_arb: RTL and testbench

- Shares one single-port unified SRAM between the core's instruction-fetch port and its data load/store port.
- Sits between the hxd32 core's iram/dram address and data buses and a single physical RAM macro.
- Per cycle: arbitrates, drives the RAM port, and tracks in-flight reads through a fixed-latency tag pipeline so each read response returns to the requester that issued it.
- Starvation guard bounds how long the instruction side can be blocked.

---
 rtl/mem_arb.sv | 165 ++++++++++++++++
 tb/tb_mem_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: shares one single-port unified SRAM between the instruction-fetch
// port and the data load/store port of the core.
//
// Each cycle at most one requester is granted and drives the RAM port
// combinationally. Reads are tracked through an RD_LAT-deep tag pipeline so
// that every read response returns to the side that issued it. A starvation
// counter forces an instruction grant after STARVE_MAX lost cycles.
//
// Optional feature: define MEM_ARB_RR_EN to replace fixed data priority with
// a 1-bit round-robin pointer (starvation override still wins).
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ireq_valid_i/addr_i/ready_o   instruction read request channel
//   irsp_valid_o/data_o           instruction read response
//   dreq_valid_i/we_i/addr_i/
//   wdata_i/byte_en_i/ready_o     data request channel
//   drsp_valid_o/data_o           data read response
//   ram_en_o/we_o/addr_o/wdata_o  RAM macro request port
//   ram_rdata_i                   RAM read data, RD_LAT cycles after a read
module mem_arb #(
  parameter int XLEN       = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ireq_valid_i,
  input  logic [XLEN-1:0] ireq_addr_i,
  output logic            ireq_ready_o,
  output logic            irsp_valid_o,
  output logic [XLEN-1:0] irsp_data_o,
  input  logic            dreq_valid_i,
  input  logic            dreq_we_i,
  input  logic [XLEN-1:0] dreq_addr_i,
  input  logic [XLEN-1:0] dreq_wdata_i,
  input  logic [3:0]      dreq_byte_en_i,
  output logic            dreq_ready_o,
  output logic            drsp_valid_o,
  output logic [XLEN-1:0] drsp_data_o,
  output logic            ram_en_o,
  output logic [3:0]      ram_we_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic [XLEN-1:0] ram_wdata_o,
  input  logic [XLEN-1:0] ram_rdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_src;   // 0 = instruction, 1 = data
  logic              gnt_i;
  logic              gnt_d;
  logic              act_i;
  logic              act_d;
  logic              rd_acc;
  logic              last_vld;

`ifdef MEM_ARB_RR_EN
  logic              rr_ptr;    // 1 = instruction preferred on contention
`endif

  // Grant selection: single requester wins outright; on contention the
  // starvation override beats the normal priority rule.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (ireq_valid_i && dreq_valid_i) begin
      if (starve_cnt == STARVE_LIM) begin
        gnt_i = 1'b1;
`ifdef MEM_ARB_RR_EN
      end else if (rr_ptr) begin
        gnt_i = 1'b1;
`endif
      end else begin
        gnt_d = 1'b1;
      end
    end else if (ireq_valid_i) begin
      gnt_i = 1'b1;
    end else if (dreq_valid_i) begin
      gnt_d = 1'b1;
    end else begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
    end
  end

  // Reset forces every output low, so grants are masked while rst_i is high.
  assign act_i  = gnt_i & ~rst_i;
  assign act_d  = gnt_d & ~rst_i;
  assign rd_acc = act_i | (act_d & ~dreq_we_i);

  assign ireq_ready_o = act_i;
  assign dreq_ready_o = act_d;

  // RAM port driven straight from the winner; idle port is all zeros.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 4'b0000;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (act_d) begin
      ram_en_o    = 1'b1;
      ram_we_o    = dreq_we_i ? dreq_byte_en_i : 4'b0000;
      ram_addr_o  = dreq_addr_i;
      ram_wdata_o = dreq_wdata_i;
    end else if (act_i) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = ireq_addr_i;
      ram_wdata_o = dreq_wdata_i;
    end else begin
      ram_en_o    = 1'b0;
    end
  end

  // Starvation counter: counts consecutive lost cycles of a waiting fetch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= 4'd0;
    end else if (!ireq_valid_i || gnt_i) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer: after a contended grant, prefer the side that lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= 1'b0;
    end else if (ireq_valid_i && dreq_valid_i) begin
      rr_ptr <= gnt_d;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`endif

  // Tag pipeline: stage 0 records each accepted read, then shifts every cycle
  // so the last stage lines up with ram_rdata_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_vld <= '0;
      tag_src <= '0;
    end else begin
      tag_vld[0] <= rd_acc;
      tag_src[0] <= act_d;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_src[i] <= tag_src[i-1];
      end
    end
  end

  assign last_vld     = tag_vld[RD_LAT-1] & ~rst_i;
  assign irsp_valid_o = last_vld & ~tag_src[RD_LAT-1];
  assign drsp_valid_o = last_vld &  tag_src[RD_LAT-1];
  assign irsp_data_o  = irsp_valid_o ? ram_rdata_i : '0;
  assign drsp_data_o  = drsp_valid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb (RD_LAT = 2, STARVE_MAX = 3,
// fixed data priority). A small behavioural RAM with RD_LAT read latency
// sits on the RAM port; expected values are hand-computed constants.
module tb_mem_arb;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        irsp_valid;
  logic [31:0] irsp_data;
  logic        dreq_valid;
  logic        dreq_we;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;
  logic [3:0]  dreq_byte_en;
  logic        dreq_ready;
  logic        drsp_valid;
  logic [31:0] drsp_data;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [0:LAT-1];

  always #5 clk = ~clk;

  mem_arb #(.XLEN(32), .RD_LAT(LAT), .STARVE_MAX(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .ireq_valid_i(ireq_valid), .ireq_addr_i(ireq_addr), .ireq_ready_o(ireq_ready),
    .irsp_valid_o(irsp_valid), .irsp_data_o(irsp_data),
    .dreq_valid_i(dreq_valid), .dreq_we_i(dreq_we), .dreq_addr_i(dreq_addr),
    .dreq_wdata_i(dreq_wdata), .dreq_byte_en_i(dreq_byte_en), .dreq_ready_o(dreq_ready),
    .drsp_valid_o(drsp_valid), .drsp_data_o(drsp_data),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Behavioural RAM: preloaded while reset is high, byte writes, LAT-cycle reads.
  always @(posedge clk) begin
    if (rst) begin
      mem[4]  <= 32'hA5A5_0010;
      mem[8]  <= 32'h5A5A_0020;
      mem[16] <= 32'h0000_0013;
      mem[64] <= 32'h0000_0000;
    end else if (ram_en && ram_we != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    rd_pipe[0] <= mem[ram_addr[9:2]];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign ram_rdata = rd_pipe[LAT-1];

  task automatic clear_inputs();
    ireq_valid   = 1'b0;
    ireq_addr    = 32'h0;
    dreq_valid   = 1'b0;
    dreq_we      = 1'b0;
    dreq_addr    = 32'h0;
    dreq_wdata   = 32'h0;
    dreq_byte_en = 4'b0000;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      clear_inputs();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    ireq_valid = 1'b1; ireq_addr = 32'h40;
    dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 32'h3FC; dreq_wdata = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({ireq_ready, dreq_ready, irsp_valid, drsp_valid, ram_en, ram_we} !== 9'b0 ||
          irsp_data !== 32'h0 || drsp_data !== 32'h0 ||
          ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got en=%b we=%b addr=%h wd=%h ir=%b dr=%b exp all 0",
                 c, ram_en, ram_we, ram_addr, ram_wdata, ireq_ready, dreq_ready);
      end
    end
    // Release with both valid: data wins first; write request so no read response.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      if (c == 2) clear_inputs();
      @(negedge clk);
      if (c < 2) begin
        total++;
        if (dreq_ready !== 1'b1 || ireq_ready !== 1'b0) begin
          bad++;
          $display("FAIL reset_first_grant cycle=%0d got d=%b i=%b exp d=1 i=0", c, dreq_ready, ireq_ready);
        end
      end
      total++;
      if (irsp_valid !== 1'b0 || drsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_rsp cycle=%0d got irsp=%b drsp=%b exp 0 0", c, irsp_valid, drsp_valid);
      end
    end
    idle(3);
  endtask

  task automatic test_inst_read();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (c == 0) begin ireq_valid = 1'b1; ireq_addr = 32'h0000_0040; end
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (ireq_ready !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 32'h40 || ram_we !== 4'b0000) begin
          bad++;
          $display("FAIL inst_req got rdy=%b en=%b addr=%h we=%b exp 1 1 00000040 0000",
                   ireq_ready, ram_en, ram_addr, ram_we);
        end
      end
      total++;
      if (irsp_valid !== (c == 2) || (c == 2 && irsp_data !== 32'h0000_0013) || drsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL inst_rsp cycle=%0d got iv=%b id=%h dv=%b exp iv=%b id=00000013 dv=0",
                 c, irsp_valid, irsp_data, drsp_valid, (c == 2));
      end
    end
    idle(2);
  endtask

  task automatic data_read_check(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (c == 0) begin dreq_valid = 1'b1; dreq_addr = addr; end
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (drsp_valid !== 1'b1 || drsp_data !== exp || irsp_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s got dv=%b dd=%h iv=%b exp dv=1 dd=%h iv=0", nm, drsp_valid, drsp_data, irsp_valid, exp);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_write();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (c == 0) begin
        dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 32'h100;
        dreq_wdata = 32'hDEAD_BEEF; dreq_byte_en = 4'b0011;
      end
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (dreq_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 4'b0011 ||
            ram_wdata !== 32'hDEAD_BEEF || ram_addr !== 32'h100) begin
          bad++;
          $display("FAIL write_port got rdy=%b en=%b we=%b wd=%h addr=%h exp 1 1 0011 deadbeef 00000100",
                   dreq_ready, ram_en, ram_we, ram_wdata, ram_addr);
        end
      end
      total++;
      if (drsp_valid !== 1'b0 || irsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL write_no_rsp cycle=%0d got dv=%b iv=%b exp 0 0", c, drsp_valid, irsp_valid);
      end
    end
    data_read_check(32'h100, 32'h0000_BEEF, "write_readback");
    // Zero byte enables: still accepted, nothing changes.
    @(posedge clk); #1;
    dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 32'h100;
    dreq_wdata = 32'hFFFF_FFFF; dreq_byte_en = 4'b0000;
    @(negedge clk);
    total++;
    if (dreq_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 4'b0000) begin
      bad++;
      $display("FAIL write_be0 got rdy=%b en=%b we=%b exp 1 1 0000", dreq_ready, ram_en, ram_we);
    end
    idle(3);
    data_read_check(32'h100, 32'h0000_BEEF, "be0_readback");
  endtask

  task automatic test_starvation();
    logic [4:0] pat;
    pat = 5'b10111;   // bit c = 1: data wins cycle c; cycle 3 goes to instruction
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (c < 5) begin
        ireq_valid = 1'b1; ireq_addr = 32'h20;
        dreq_valid = 1'b1; dreq_addr = 32'h10;
      end
      @(negedge clk);
      if (c < 5) begin
        total++;
        if (dreq_ready !== pat[c] || ireq_ready !== !pat[c]) begin
          bad++;
          $display("FAIL starve_grant cycle=%0d got d=%b i=%b exp d=%b i=%b",
                   c, dreq_ready, ireq_ready, pat[c], !pat[c]);
        end
      end
      if (c >= 2) begin
        total++;
        if (drsp_valid !== pat[c-2] || irsp_valid !== !pat[c-2] ||
            (pat[c-2] && drsp_data !== 32'hA5A5_0010) ||
            (!pat[c-2] && irsp_data !== 32'h5A5A_0020)) begin
          bad++;
          $display("FAIL starve_rsp cycle=%0d got dv=%b dd=%h iv=%b id=%h exp dv=%b",
                   c, drsp_valid, drsp_data, irsp_valid, irsp_data, pat[c-2]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_interleaved();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (c == 0) begin dreq_valid = 1'b1; dreq_addr = 32'h10; end
      if (c == 1) begin ireq_valid = 1'b1; ireq_addr = 32'h20; end
      @(negedge clk);
      total++;
      if (drsp_valid !== (c == 2) || irsp_valid !== (c == 3) ||
          (c == 2 && drsp_data !== 32'hA5A5_0010) || (c == 3 && irsp_data !== 32'h5A5A_0020)) begin
        bad++;
        $display("FAIL interleave cycle=%0d got dv=%b dd=%h iv=%b id=%h", c, drsp_valid, drsp_data, irsp_valid, irsp_data);
      end
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [0:2];
    logic [31:0] exps  [0:2];
    addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h40;
    exps[0]  = 32'hA5A5_0010; exps[1] = 32'h5A5A_0020; exps[2] = 32'h0000_0013;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (c < 3) begin dreq_valid = 1'b1; dreq_addr = addrs[c]; end
      @(negedge clk);
      if (c < 3) begin
        total++;
        if (dreq_ready !== 1'b1 || ram_addr !== addrs[c]) begin
          bad++;
          $display("FAIL b2b_grant cycle=%0d got rdy=%b addr=%h exp 1 %h", c, dreq_ready, ram_addr, addrs[c]);
        end
      end
      if (c >= 2) begin
        total++;
        if (drsp_valid !== 1'b1 || drsp_data !== exps[c-2]) begin
          bad++;
          $display("FAIL b2b_rsp cycle=%0d got dv=%b dd=%h exp 1 %h", c, drsp_valid, drsp_data, exps[c-2]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_read();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      clear_inputs();
      rst = (c == 1);
      if (c == 0) begin ireq_valid = 1'b1; ireq_addr = 32'h40; end
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (ireq_ready !== 1'b1) begin
          bad++;
          $display("FAIL midrst_accept got %b exp 1", ireq_ready);
        end
      end else begin
        total++;
        if (irsp_valid !== 1'b0 || drsp_valid !== 1'b0) begin
          bad++;
          $display("FAIL midrst_no_rsp cycle=%0d got iv=%b dv=%b exp 0 0", c, irsp_valid, drsp_valid);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_inst_read();
    test_write();
    test_starvation();
    test_interleaved();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
